// File: rtl/fetch_pkg.sv
// Shared constants and state type for the instruction fetch unit.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;

  typedef enum logic {
    StRun   = 1'b0,
    StDrain = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_queue #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_inc(wptr_q);
      if (do_pop)  rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage is cleared only on reset so the decode-side outputs read zero afterwards.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory requests, buffers responses for decode,
// and drains stale responses after a redirect. Optional FETCH_PERF_CNT_EN adds fetch_count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, resp_pc_q, target;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, q_count;
  logic            fire, resp, accept, push, pop, q_full, q_empty;
  logic [2*XLEN-1:0] q_head;

  assign target = redirect_pc & ~XLEN'(3);
  assign fire   = imem_req && imem_gnt;
  // A response with nothing in flight is a leftover from before reset.
  assign resp   = imem_rvalid && ((out_q != '0) || (disc_q != '0));
  assign accept = resp && (disc_q == '0);
  assign push   = accept && !redirect_valid && (!q_full || pop);
  assign pop    = id_valid && id_ready && !redirect_valid;

  assign imem_req  = rst && (state_q == StRun) && ((32'(out_q) + 32'(q_count)) < QDEPTH);
  assign imem_addr = pc_q;
  assign id_valid  = !q_empty;
  assign id_pc     = q_head[2*XLEN-1:XLEN];
  assign id_instr  = q_head[XLEN-1:0];

  // On redirect every request still in flight becomes a discard, including one granted now.
  always_comb begin
    out_d   = out_q;
    disc_d  = disc_q;
    state_d = state_q;
    if (redirect_valid) begin
      out_d   = '0;
      disc_d  = disc_q + out_q + CW'(fire) - CW'(resp);
      state_d = (disc_d != '0) ? StDrain : StRun;
    end else begin
      out_d = out_q + CW'(fire) - CW'(accept);
      if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
      if ((state_q == StDrain) && (disc_d == '0)) state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      if (redirect_valid) begin
        pc_q      <= target;
        resp_pc_q <= target;
      end else begin
        if (fire) pc_q      <= pc_q + XLEN'(4);
        if (push) resp_pc_q <= resp_pc_q + XLEN'(4);
      end
    end
  end

  fetch_queue #(
    .Width (2 * XLEN),
    .Depth (QDEPTH)
  ) u_queue (
    .clk_i       (clk),
    .rst_ni      (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({resp_pc_q, imem_rdata}),
    .pop_i       (pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk) begin
    if (!rst)     fetch_count_q <= '0;
    else if (pop) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: flow, backpressure, redirects, PC wrap and mid-stream reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] dat(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rsp(input logic v, input logic [31:0] a);
    imem_rvalid = v;
    imem_rdata  = v ? dat(a) : 32'h0;
  endtask

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_idv", id_valid, 0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_idpc", id_pc, 32'h0);

    // Streaming with gnt=1, response one cycle after grant, decode always ready
    rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; settle();
    chk("a0_req", imem_req, 1); chk("a0_addr", imem_addr, 32'h0);
    tick(); rsp(1, 32'h0); settle();
    chk("a1_req", imem_req, 1); chk("a1_addr", imem_addr, 32'h4); chk("a1_idv", id_valid, 0);
    tick(); rsp(1, 32'h4); settle();
    chk("a2_req_full", imem_req, 0); chk("a2_idv", id_valid, 1);
    chk("a2_idpc", id_pc, 32'h0); chk("a2_instr", id_instr, dat(32'h0));
    tick(); rsp(0, 0); settle();
    chk("a3_req", imem_req, 1); chk("a3_addr", imem_addr, 32'h8);
    chk("a3_idpc", id_pc, 32'h4); chk("a3_instr", id_instr, dat(32'h4));
    tick(); rsp(1, 32'h8); imem_gnt = 1'b0; settle();
    chk("a4_idv", id_valid, 0);
    tick(); rsp(0, 0); settle();
    chk("a5_idpc", id_pc, 32'h8); chk("a5_instr", id_instr, dat(32'h8));
    tick(); settle();
    chk("a6_idv", id_valid, 0);

    // Backpressure: decode stalls five cycles
    id_ready = 1'b0; imem_gnt = 1'b1; settle();
    chk("b0_addr", imem_addr, 32'hC);
    tick(); rsp(1, 32'hC); settle();
    chk("b1_req", imem_req, 1); chk("b1_addr", imem_addr, 32'h10);
    tick(); rsp(1, 32'h10); settle();
    chk("b2_req", imem_req, 0); chk("b2_idpc", id_pc, 32'hC);
    tick(); rsp(0, 0); settle();
    chk("b3_req", imem_req, 0); chk("b3_idpc", id_pc, 32'hC); chk("b3_instr", id_instr, dat(32'hC));
    tick(); settle();
    chk("b4_req", imem_req, 0); chk("b4_idpc", id_pc, 32'hC);
    tick(); id_ready = 1'b1; settle();
    chk("b5_idpc", id_pc, 32'hC); chk("b5_instr", id_instr, dat(32'hC));
    tick(); imem_gnt = 1'b0; settle();
    chk("b6_idpc", id_pc, 32'h10); chk("b6_instr", id_instr, dat(32'h10));
    chk("b6_req", imem_req, 1);
    tick(); settle();
    chk("b7_idv", id_valid, 0);

    // Redirect to 0x103 with two requests outstanding
    imem_gnt = 1'b1; settle();
    chk("c0_addr", imem_addr, 32'h14);
    tick(); settle();
    chk("c1_addr", imem_addr, 32'h18);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; settle();
    chk("c2_req", imem_req, 0);
    tick(); redirect_valid = 1'b0; rsp(1, 32'h14); settle();
    chk("c3_drain_req", imem_req, 0); chk("c3_idv", id_valid, 0);
    chk("c3_addr", imem_addr, 32'h100);
    tick(); rsp(1, 32'h18); settle();
    chk("c4_drain_req", imem_req, 0);
    tick(); rsp(0, 0); settle();
    chk("c5_idv_dropped", id_valid, 0);
    chk("c5_req", imem_req, 1); chk("c5_addr", imem_addr, 32'h100);
    tick(); imem_gnt = 1'b0; rsp(1, 32'h100); settle();
    chk("c6_idv", id_valid, 0);
    tick(); rsp(0, 0); settle();
    chk("c7_idv", id_valid, 1); chk("c7_idpc", id_pc, 32'h100);
    chk("c7_instr", id_instr, dat(32'h100));
    tick(); settle();

    // Redirect coinciding with a grant and a response
    imem_gnt = 1'b1; settle();
    chk("d0_addr", imem_addr, 32'h104);
    tick(); rsp(1, 32'h104); redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
    chk("d1_req", imem_req, 1); chk("d1_addr", imem_addr, 32'h108);
    tick(); redirect_valid = 1'b0; imem_gnt = 1'b0; rsp(0, 0); settle();
    chk("d2_req", imem_req, 0); chk("d2_idv_nopush", id_valid, 0);
    chk("d2_addr", imem_addr, 32'h200);
    tick(); rsp(1, 32'h108); settle();
    chk("d3_idv", id_valid, 0);
    tick(); rsp(0, 0); settle();
    chk("d4_req", imem_req, 1); chk("d4_addr", imem_addr, 32'h200); chk("d4_idv", id_valid, 0);

`ifdef FETCH_PERF_CNT_EN
    chk("perf_before_wrap", fetch_count, 32'd6);
`endif

    // PC wrap at the top of the address space
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    tick(); redirect_valid = 1'b0; imem_gnt = 1'b1; settle();
    chk("e1_req", imem_req, 1); chk("e1_addr", imem_addr, 32'hFFFF_FFFC);
    tick(); imem_gnt = 1'b0; rsp(1, 32'hFFFF_FFFC); settle();
    chk("e2_addr_wrap", imem_addr, 32'h0);
    tick(); rsp(0, 0); settle();
    chk("e3_idpc", id_pc, 32'hFFFF_FFFC); chk("e3_instr", id_instr, 32'h0FFF_FFFC);
    tick(); settle();

    // Mid-stream reset with data buffered and a response still in flight
    imem_gnt = 1'b1; id_ready = 1'b0; settle();
    chk("f0_addr", imem_addr, 32'h0);
    tick(); rsp(1, 32'h0); settle();
    tick(); rsp(0, 0); imem_gnt = 1'b0; rst = 1'b0; settle();
    chk("f2_req_in_rst", imem_req, 0);
    tick(); rst = 1'b1; rsp(1, 32'h4); settle();
    chk("f3_idv", id_valid, 0); chk("f3_instr", id_instr, 32'h0);
    chk("f3_idpc", id_pc, 32'h0); chk("f3_addr", imem_addr, 32'h0);
    chk("f3_req_first", imem_req, 1);
`ifdef FETCH_PERF_CNT_EN
    chk("f3_perf", fetch_count, 32'd0);
`endif
    tick(); rsp(0, 0); settle();
    chk("f4_stale_ignored", id_valid, 0);
    imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; rsp(1, 32'h0); settle();
    tick(); rsp(0, 0); settle();
    chk("f6_idv", id_valid, 1); chk("f6_idpc", id_pc, 32'h0);
    chk("f6_instr", id_instr, dat(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
